// File: rtl/tdp_ram_be.sv
// tdp_ram_be: true dual-port synchronous RAM with byte-write enables.
// Storage is sliced into one memory per byte lane, so each lane has two
// independent write ports. A two-state sequencer fills every word with
// INIT_VAL after reset. Cross-port collisions are flagged and counted.
module tdp_ram_be #(
    parameter int                DATA_W   = 128,
    parameter int                ADDR_W   = 3,
    parameter int                BYTE_W   = 8,
    parameter int                RD_MODE  = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done,
    input  logic                       en_a,
    input  logic                       wr_en_a,
    input  logic [DATA_W/BYTE_W-1:0]   be_a,
    input  logic [ADDR_W-1:0]          addr_a,
    input  logic [DATA_W-1:0]          data_in_a,
    output logic [DATA_W-1:0]          data_out_a,
    output logic                       valid_a,
    input  logic                       en_b,
    input  logic                       wr_en_b,
    input  logic [DATA_W/BYTE_W-1:0]   be_b,
    input  logic [ADDR_W-1:0]          addr_b,
    input  logic [DATA_W-1:0]          data_in_b,
    output logic [DATA_W-1:0]          data_out_b,
    output logic                       valid_b,
    output logic                       collision,
    output logic [15:0]                coll_cnt
);

    localparam int                NBE   = DATA_W / BYTE_W;
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    // A word width that is not a whole number of lanes cannot be byte-enabled.
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("tdp_ram_be: DATA_W must be a multiple of BYTE_W");
    end

    // ------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------
    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state, state_nxt;
    logic              init_fin;
    logic              ready;
    logic [ADDR_W-1:0] ptr;

    assign ready = (state == ST_READY);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // Leave INIT on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        init_fin  = 1'b0;
        case (state)
            ST_INIT: begin
                if (ptr == LAST) begin
                    state_nxt = ST_READY;
                    init_fin  = 1'b1;
                end
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Fill pointer walks the array once; init_done rises with the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == ST_INIT) ptr <= ptr + 1'b1;
            if (init_fin)         init_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Port bundles: index 0 = port A, 1 = port B. Requests are gated by
    // ready so nothing is written, read or counted during INIT.
    // ------------------------------------------------------------------
    logic [1:0]             en_p, wr_p;
    logic [1:0][ADDR_W-1:0] addr_p;
    logic [1:0][NBE-1:0]    be_p;
    logic [1:0][DATA_W-1:0] din_p, old_p, rd_p, d1_p, dout_p;
    logic [1:0]             v1_p, vout_p;
    logic                   same_addr;
    logic                   coll_hit;

    assign en_p      = {en_b & ready, en_a & ready};
    assign wr_p      = en_p & {wr_en_b, wr_en_a};
    assign addr_p    = {addr_b, addr_a};
    assign be_p      = {be_b, be_a};
    assign din_p     = {data_in_b, data_in_a};
    assign same_addr = (addr_a == addr_b);
    assign coll_hit  = en_p[0] & en_p[1] & same_addr & (wr_en_a | wr_en_b);

    // ------------------------------------------------------------------
    // Byte-lane storage
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NBE; k++) begin : g_lane
        logic [BYTE_W-1:0] mem [DEPTH];
        logic              a_hit, b_hit;

        // Port A owns a lane it enables; B only writes the lane otherwise.
        assign a_hit = wr_p[0] & be_p[0][k];
        assign b_hit = wr_p[1] & be_p[1][k] & ~(a_hit & same_addr);

        // Lane write: init fill, else up to two independent port writes.
        always_ff @(posedge clk) begin
            if (!ready) begin
                mem[ptr] <= INIT_VAL[k*BYTE_W +: BYTE_W];
            end else begin
                if (b_hit) mem[addr_p[1]] <= din_p[1][k*BYTE_W +: BYTE_W];
                if (a_hit) mem[addr_p[0]] <= din_p[0][k*BYTE_W +: BYTE_W];
            end
        end

        // Read path: old lane, or own write data in write-first mode.
        // A port that only reads never sees the other port's write.
        for (genvar p = 0; p < 2; p++) begin : g_rd
            assign old_p[p][k*BYTE_W +: BYTE_W] = mem[addr_p[p]];
            assign rd_p[p][k*BYTE_W +: BYTE_W] =
                (RD_MODE != 0 && wr_p[p] && be_p[p][k]) ?
                    din_p[p][k*BYTE_W +: BYTE_W] : old_p[p][k*BYTE_W +: BYTE_W];
        end
    end

    // ------------------------------------------------------------------
    // Read output pipeline
    // ------------------------------------------------------------------
    // First read stage: data only loads on an access so it holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_p <= '0;
            d1_p <= '0;
        end else begin
            v1_p <= en_p;
            for (int p = 0; p < 2; p++) begin
                if (en_p[p]) d1_p[p] <= rd_p[p];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [1:0]             v2;
        logic [1:0][DATA_W-1:0] d2;

        // Optional second stage, same hold-on-idle behaviour.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= '0;
                d2 <= '0;
            end else begin
                v2 <= v1_p;
                for (int p = 0; p < 2; p++) begin
                    if (v1_p[p]) d2[p] <= d1_p[p];
                end
            end
        end

        assign vout_p = v2;
        assign dout_p = d2;
    end else begin : g_noreg
        assign vout_p = v1_p;
        assign dout_p = d1_p;
    end

    assign valid_a    = vout_p[0];
    assign valid_b    = vout_p[1];
    assign data_out_a = dout_p[0];
    assign data_out_b = dout_p[1];

    // ------------------------------------------------------------------
    // Collision flag and saturating counter
    // ------------------------------------------------------------------
    // Pulse and count land on the edge after the colliding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            collision <= coll_hit;
            if (coll_hit && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: two instances share one stimulus stream
// (dut0 = read-first, latency 1; dut1 = write-first, latency 2) and are
// compared every cycle against a word-level memory model.
module tb_tdp_ram_be;

    localparam int           DW    = 128;
    localparam int           AW    = 3;
    localparam int           NB    = 16;
    localparam int           DEPTH = 8;
    localparam logic [DW-1:0] IV   = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    localparam logic [DW-1:0] ALL55 = {16{8'h55}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_a = 0, wr_en_a = 0, en_b = 0, wr_en_b = 0;
    logic [NB-1:0] be_a = '0, be_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] data_in_a = '0, data_in_b = '0;

    logic [DW-1:0] dout_a [2];
    logic [DW-1:0] dout_b [2];
    logic          va [2];
    logic          vb [2];
    logic          coll [2];
    logic [15:0]   cnt [2];
    logic          idone [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        tdp_ram_be #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .RD_MODE(d),
                     .OUT_REG(d), .INIT_VAL(IV)) u_dut (
            .clk(clk), .rst(rst), .init_done(idone[d]),
            .en_a(en_a), .wr_en_a(wr_en_a), .be_a(be_a), .addr_a(addr_a),
            .data_in_a(data_in_a), .data_out_a(dout_a[d]), .valid_a(va[d]),
            .en_b(en_b), .wr_en_b(wr_en_b), .be_b(be_b), .addr_b(addr_b),
            .data_in_b(data_in_b), .data_out_b(dout_b[d]), .valid_b(vb[d]),
            .collision(coll[d]), .coll_cnt(cnt[d]));
    end

    // ---------------- model state ----------------
    logic [DW-1:0] mm [DEPTH];
    int            init_left;
    logic [DW-1:0] e_da [2];
    logic [DW-1:0] e_db [2];
    logic          e_va [2];
    logic          e_vb [2];
    logic          p_va, p_vb;
    logic [DW-1:0] p_da, p_db;
    logic          e_coll, e_done;
    logic [15:0]   e_cnt;
    int            n_cmp = 0, n_bad = 0;
    logic          chk_en = 1'b0;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] din,
                                            logic [NB-1:0] be);
        logic [DW-1:0] r = old;
        for (int k = 0; k < NB; k++) if (be[k]) r[k*8 +: 8] = din[k*8 +: 8];
        return r;
    endfunction

    task automatic chk(string nm, int d, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
        end
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mm[i] = IV;
        for (int d = 0; d < 2; d++) begin
            e_da[d] = '0; e_db[d] = '0; e_va[d] = 0; e_vb[d] = 0;
        end
        p_va = 0; p_vb = 0; p_da = '0; p_db = '0;
        e_coll = 0; e_cnt = '0; e_done = 0;
    endtask

    // One clock edge: advance the model with the inputs the DUT samples.
    task automatic step();
        logic          rdy, ra, rb, wa, wb, col;
        logic [DW-1:0] oa, ob, na, nb;
        @(posedge clk);
        rdy = (init_left == 0);
        ra  = rdy & en_a;      rb = rdy & en_b;
        wa  = ra & wr_en_a;    wb = rb & wr_en_b;
        oa  = mm[addr_a];      ob = mm[addr_b];
        na  = wa ? merge(oa, data_in_a, be_a) : oa;
        nb  = wb ? merge(ob, data_in_b, be_b) : ob;
        col = ra & rb & (addr_a == addr_b) & (wr_en_a | wr_en_b);
        if (wb) mm[addr_b] = merge(mm[addr_b], data_in_b,
                                   (wa && addr_a == addr_b) ? (be_b & ~be_a) : be_b);
        if (wa) mm[addr_a] = merge(mm[addr_a], data_in_a, be_a);
        if (!rdy) init_left--;
        e_done = (init_left == 0);
        e_va[0] = ra; if (ra) e_da[0] = oa;
        e_vb[0] = rb; if (rb) e_db[0] = ob;
        e_va[1] = p_va; if (p_va) e_da[1] = p_da;
        e_vb[1] = p_vb; if (p_vb) e_db[1] = p_db;
        p_va = ra; if (ra) p_da = na;
        p_vb = rb; if (rb) p_db = nb;
        e_coll = col;
        if (col && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        #1;
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("data_out_a", d, dout_a[d], e_da[d]);
                chk("valid_a",    d, DW'(va[d]), DW'(e_va[d]));
                chk("data_out_b", d, dout_b[d], e_db[d]);
                chk("valid_b",    d, DW'(vb[d]), DW'(e_vb[d]));
                chk("collision",  d, DW'(coll[d]), DW'(e_coll));
                chk("coll_cnt",   d, DW'(cnt[d]), DW'(e_cnt));
                chk("init_done",  d, DW'(idone[d]), DW'(e_done));
            end
        end
    end

    task automatic idle();
        en_a = 0; wr_en_a = 0; en_b = 0; wr_en_b = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rnd_inputs(int amax);
        en_a = ($urandom_range(0, 3) != 0); wr_en_a = $urandom_range(0, 1);
        en_b = ($urandom_range(0, 3) != 0); wr_en_b = $urandom_range(0, 1);
        be_a = NB'($urandom); be_b = NB'($urandom);
        addr_a = AW'($urandom_range(0, amax)); addr_b = AW'($urandom_range(0, amax));
        data_in_a = {$urandom, $urandom, $urandom, $urandom};
        data_in_b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wr_a(logic [AW-1:0] a, logic [DW-1:0] dat, logic [NB-1:0] be);
        en_a = 1; wr_en_a = 1; addr_a = a; data_in_a = dat; be_a = be;
        step();
        idle();
    endtask

    // Read on port B and pin the result with a literal at each latency.
    task automatic rd_b_lit(string nm, logic [AW-1:0] a, logic [DW-1:0] exp);
        en_b = 1; wr_en_b = 0; addr_b = a;
        step();
        idle();
        chk(nm, 0, dout_b[0], exp);
        chk({nm, "_valid"}, 0, DW'(vb[0]), DW'(1));
        step();
        chk(nm, 1, dout_b[1], exp);
        chk({nm, "_valid"}, 1, DW'(vb[1]), DW'(1));
    endtask

    initial begin
        int n;
        // 1: reset, init edge count, requests ignored during INIT.
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (idone[0] !== 1'b1 && n < 20) begin
            rnd_inputs(7);
            step();
            n++;
        end
        idle();
        chk("init_edges", 0, DW'(n), DW'(DEPTH));
        chk("init_done_lit", 1, DW'(idone[1]), DW'(1));
        for (int i = 0; i < DEPTH; i++) rd_b_lit("init_word", AW'(i), IV);

        // 2: A writes pattern, B reads back.
        for (int i = 0; i < DEPTH; i++)
            wr_a(AW'(i), {64'hAAAA0000AAAA0000, 64'(i)}, '1);
        for (int i = 0; i < DEPTH; i++)
            rd_b_lit("pattern", AW'(i), {64'hAAAA0000AAAA0000, 64'(i)});

        // 3: partial byte write.
        wr_a(3'd2, {16{8'h11}}, '1);
        wr_a(3'd2, '1, 16'h00FF);
        rd_b_lit("byte_en", 3'd2, 128'h1111111111111111_FFFFFFFFFFFFFFFF);

        // 4: same-port read during write.
        en_a = 1; wr_en_a = 1; addr_a = 3'd3; data_in_a = ALL55; be_a = '1;
        step();
        idle();
        chk("rdw_old", 0, dout_a[0], {64'hAAAA0000AAAA0000, 64'd3});
        step();
        chk("rdw_new", 1, dout_a[1], ALL55);
        rd_b_lit("rdw_after", 3'd3, ALL55);

        // 5: dual write collision, then saturation.
        en_a = 1; wr_en_a = 1; addr_a = 3'd5; data_in_a = {16{8'hAA}}; be_a = 16'h00FF;
        en_b = 1; wr_en_b = 1; addr_b = 3'd5; data_in_b = {16{8'hBB}}; be_b = 16'hFFFF;
        step();
        idle();
        for (int d = 0; d < 2; d++) begin
            chk("coll_pulse", d, DW'(coll[d]), DW'(1));
            chk("coll_cnt1",  d, DW'(cnt[d]), DW'(1));
        end
        step();
        chk("coll_clear", 0, DW'(coll[0]), DW'(0));
        rd_b_lit("coll_word", 3'd5, 128'hBBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA);
        en_a = 1; wr_en_a = 1; addr_a = 3'd6; be_a = '1;
        en_b = 1; wr_en_b = 0; addr_b = 3'd6;
        for (int i = 0; i < 70000; i++) begin
            data_in_a = {4{$urandom}};
            step();
        end
        idle();
        step();
        chk("coll_sat", 0, DW'(cnt[0]), DW'(16'hFFFF));
        chk("coll_sat", 1, DW'(cnt[1]), DW'(16'hFFFF));

        // Random traffic, narrow address range for frequent collisions.
        for (int i = 0; i < 1500; i++) begin
            rnd_inputs((i < 750) ? 3 : 7);
            step();
        end
        idle();

        // 6: reset with a read in flight.
        en_b = 1; wr_en_b = 0; addr_b = 3'd5;
        step();
        idle();
        #1 rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, DW'(vb[d]), DW'(0));
            chk("rst_dout",  d, dout_b[d], '0);
            chk("rst_done",  d, DW'(idone[d]), DW'(0));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) step();
        rd_b_lit("reinit_word", 3'd5, IV);
        for (int i = 0; i < 300; i++) begin
            rnd_inputs(3);
            step();
        end
        idle();
        step();
        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
